multu_seq: RTL and testbench

- Sequential shift-add unsigned multiplier that executes MIPS multu and writes the HI/LO registers.
- It is the responder end of the stall handshake: the decode-stage stall logic issues the start and freezes the PC, and this block completes in a fixed 32 iterations and reports busy/done.
- It sits in the EX stage beside the ALU. mfhi/mflo read its hi/lo outputs; mthi/mtlo write them.

---
 rtl/cpu_pkg.sv | 14 +
 rtl/multu_seq_if.sv | 25 ++
 rtl/multu_seq.sv | 72 +++++++
 tb/tb_multu_seq.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Definitions shared between the EX-stage multiplier and the decode-stage stall logic.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } multu_state_e;

  localparam logic [5:0] FUNCT_MULTU  = 6'd25;
  // The decoder's stall count and the multiplier's iteration count both derive from this.
  localparam int         MULTU_CYCLES = 32;

endpackage

// File: rtl/multu_seq_if.sv
// Start/operand, mthi/mtlo and HI/LO result signals between the EX stage and the multiplier.
interface multu_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             wr_hi;
  logic             wr_lo;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, opa, opb, wr_hi, wr_lo, wdata,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, opa, opb, wr_hi, wr_lo, wdata,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/multu_seq.sv
// Sequential shift-add unsigned multiplier for MIPS multu.
// It owns the HI/LO registers and produces one product bit per clock.
module multu_seq
  import cpu_pkg::*;
#(
  parameter int WIDTH = MULTU_CYCLES,
  parameter int CNT_W = 6
) (
  input  logic        clk,
  input  logic        rst,
  multu_seq_if.slave  bus
);

  multu_state_e         state_q;
  logic [WIDTH-1:0]     mcand_q;
  logic [2*WIDTH-1:0]   prod_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [WIDTH-1:0]     hi_q;
  logic [WIDTH-1:0]     lo_q;

  logic [WIDTH:0]       sum_d;
  logic [2*WIDTH-1:0]   prod_d;

  // The extra top bit of sum_d keeps the adder carry, which the shift moves into the product.
  always_comb begin
    sum_d  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, (prod_q[0] ? mcand_q : {WIDTH{1'b0}})};
    prod_d = {sum_d, prod_q[WIDTH-1:1]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      mcand_q <= '0;
      prod_q  <= '0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          // In DONE, a strobe overwrites the result that was already committed at the last iteration.
          if (bus.wr_hi) hi_q <= bus.wdata;
          if (bus.wr_lo) lo_q <= bus.wdata;
          if (bus.start) begin
            mcand_q <= bus.opa;
            prod_q  <= {{WIDTH{1'b0}}, bus.opb};
            cnt_q   <= '0;
            state_q <= RUN;
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          prod_q <= prod_d;
          cnt_q  <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            hi_q    <= prod_d[2*WIDTH-1:WIDTH];
            lo_q    <= prod_d[WIDTH-1:0];
            state_q <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy = (state_q == RUN);
  assign bus.done = (state_q == DONE);
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_multu_seq.sv
// Directed bench for multu_seq: a product table followed by the multi-cycle corner sequences.
module tb_multu_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  multu_seq_if #(.WIDTH(32)) mif ();

  multu_seq #(.WIDTH(32), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (mif.slave)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [31:0] a, input logic [31:0] b);
    mif.start = 1'b1;
    mif.opa   = a;
    mif.opb   = b;
  endtask

  // Caller has start/opa/opb set up; the first edge here is E0. Returns in the done cycle.
  // mode 1: pulse start (7x7) after edge E<at>; mode 2: pulse wr_hi after edge E<at>.
  task automatic run_op(input string name, input logic [31:0] ehi, input logic [31:0] elo,
                        input int mode, input int at, input logic [31:0] emid);
    int busy_cnt;
    int done_k;
    busy_cnt = 0;
    done_k   = -1;
    tick();
    mif.start = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (mif.done) begin
        done_k = k;
        break;
      end
      if (mif.busy) busy_cnt++;
      if (mode == 2 && k == at + 1) chk({name, " hi held in RUN"}, mif.hi, emid);
      mif.wr_hi = (mode == 2 && k == at);
      mif.wdata = 32'h5555_5555;
      if (mode == 1 && k == at) begin
        mif.start = 1'b1;
        mif.opa   = 32'd7;
        mif.opb   = 32'd7;
      end else begin
        mif.start = 1'b0;
      end
      tick();
    end
    mif.wr_hi = 1'b0;
    mif.start = 1'b0;
    chk({name, " busy cycles"}, 32'(busy_cnt), 32'd32);
    chk({name, " done cycle"}, 32'(done_k), 32'd32);
    chk({name, " hi"}, mif.hi, ehi);
    chk({name, " lo"}, mif.lo, elo);
    $display("op %s: hi=0x%08h lo=0x%08h busy_cycles=%0d done_at=%0d",
             name, mif.hi, mif.lo, busy_cnt, done_k);
  endtask

  initial begin
    int seen_done;

    vecs[0] = '{a: 32'd3,          b: 32'd5,          hi: 32'h0000_0000, lo: 32'h0000_000F};
    vecs[1] = '{a: 32'hFFFF_FFFF,  b: 32'hFFFF_FFFF,  hi: 32'hFFFF_FFFE, lo: 32'h0000_0001};
    vecs[2] = '{a: 32'h0001_0000,  b: 32'h0001_0000,  hi: 32'h0000_0001, lo: 32'h0000_0000};
    vecs[3] = '{a: 32'h1234_5678,  b: 32'h9ABC_DEF0,  hi: 32'h0B00_EA4E, lo: 32'h242D_2080};
    vecs[4] = '{a: 32'hFFFF_FFFF,  b: 32'd1,          hi: 32'h0000_0000, lo: 32'hFFFF_FFFF};
    vecs[5] = '{a: 32'h8000_0000,  b: 32'd2,          hi: 32'h0000_0001, lo: 32'h0000_0000};
    vecs[6] = '{a: 32'hFFFF_FFFF,  b: 32'h10,         hi: 32'h0000_000F, lo: 32'hFFFF_FFF0};

    mif.start = 1'b0;
    mif.opa   = '0;
    mif.opb   = '0;
    mif.wr_hi = 1'b0;
    mif.wr_lo = 1'b0;
    mif.wdata = '0;
    rst       = 1'b1;
    #1;
    chk("reset busy", 32'(mif.busy), 32'd0);
    chk("reset done", 32'(mif.done), 32'd0);
    chk("reset hi", mif.hi, 32'd0);
    chk("reset lo", mif.lo, 32'd0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    tick();

    for (int i = 0; i < 7; i++) begin
      launch(vecs[i].a, vecs[i].b);
      run_op($sformatf("vec%0d", i), vecs[i].hi, vecs[i].lo, 0, 0, 32'd0);
      tick();
      chk($sformatf("vec%0d done drop", i), 32'(mif.done), 32'd0);
      chk($sformatf("vec%0d idle busy", i), 32'(mif.busy), 32'd0);
    end

    // start pulsed during RUN must not disturb the operation in flight
    launch(32'h0001_0000, 32'h0001_0000);
    run_op("ignore_start", 32'd1, 32'd0, 1, 10, 32'd0);
    tick();

    // back-to-back: second start issued in the DONE cycle
    launch(32'd2, 32'd3);
    run_op("b2b_first", 32'd0, 32'd6, 0, 0, 32'd0);
    launch(32'd4, 32'd5);
    run_op("b2b_second", 32'd0, 32'd20, 0, 0, 32'd0);
    tick();

    // mtlo strobe in the DONE cycle wins over the committed product
    launch(32'h8000_0000, 32'd2);
    run_op("done_strobe", 32'd1, 32'd0, 0, 0, 32'd0);
    mif.wr_lo = 1'b1;
    mif.wdata = 32'h1111_1111;
    tick();
    mif.wr_lo = 1'b0;
    chk("done_strobe lo", mif.lo, 32'h1111_1111);
    chk("done_strobe hi", mif.hi, 32'd1);

    // asynchronous reset mid-operation
    launch(32'h1234_5678, 32'h9ABC_DEF0);
    tick();
    mif.start = 1'b0;
    repeat (15) tick();
    #2 rst = 1'b1;
    #1;
    chk("abort busy", 32'(mif.busy), 32'd0);
    chk("abort done", 32'(mif.done), 32'd0);
    chk("abort hi", mif.hi, 32'd0);
    chk("abort lo", mif.lo, 32'd0);
    @(posedge clk);
    #2 rst = 1'b0;
    seen_done = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (mif.done || mif.busy) seen_done = 1;
    end
    chk("abort no done", 32'(seen_done), 32'd0);
    launch(32'h1234_5678, 32'h9ABC_DEF0);
    run_op("after_reset", 32'h0B00_EA4E, 32'h242D_2080, 0, 0, 32'd0);
    tick();

    // mthi/mtlo in IDLE, then wr_hi during RUN is ignored
    mif.wr_hi = 1'b1;
    mif.wdata = 32'hDEAD_BEEF;
    tick();
    mif.wr_hi = 1'b0;
    mif.wr_lo = 1'b1;
    mif.wdata = 32'hCAFE_F00D;
    tick();
    mif.wr_lo = 1'b0;
    chk("mthi", mif.hi, 32'hDEAD_BEEF);
    chk("mtlo", mif.lo, 32'hCAFE_F00D);
    launch(32'd0, 32'h1234);
    run_op("mt_run", 32'd0, 32'd0, 2, 5, 32'hDEAD_BEEF);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
